// File: rtl/dense_seq_ctrl_pkg.sv
// dense_seq_ctrl_pkg: shared state encoding, defaults and chunk sizing for the dense sequencer
package dense_seq_ctrl_pkg;
    localparam int TAPS_DEF     = 9;
    localparam int MAC_LAT_DEF  = 2;
    localparam int ROWLEN_DENSE = 1;
    localparam int ROWLEN_W_DEF = 8;
    typedef enum logic [2:0] {IDLE, CLEAR, LOAD_W, LOAD_X, FIRE, WAIT, EMIT} state_e;
    function automatic logic [7:0] chunk_k(input logic [31:0] rem, input int taps);
        return (rem > 32'(taps)) ? 8'(taps) : rem[7:0];
    endfunction
endpackage

// File: rtl/dense_seq_ctrl_if.sv
// dense_seq_ctrl_if: control, upstream handshake and datapath-control signals of the dense sequencer
interface dense_seq_ctrl_if import dense_seq_ctrl_pkg::*; #(
    parameter int LEN_W    = 16,
    parameter int ROWLEN_W = ROWLEN_W_DEF
);
    logic                start;
    logic [LEN_W-1:0]    in_len;
    logic                busy;
    logic                done;
    logic                weight_valid;
    logic                weight_ready;
    logic                feature_valid;
    logic                feature_ready;
    logic                line_buffer_reset;
    logic [ROWLEN_W-1:0] row_length;
    logic                shifting_filter;
    logic                shifting_line;
    logic [7:0]          dense_valid;
    logic                mac_enable;
    logic                out_valid;
    logic                out_last;
    modport master(
        input  start, in_len, weight_valid, feature_valid,
        output busy, done, weight_ready, feature_ready, line_buffer_reset, row_length,
               shifting_filter, shifting_line, dense_valid, mac_enable, out_valid, out_last
    );
    modport slave(
        output start, in_len, weight_valid, feature_valid,
        input  busy, done, weight_ready, feature_ready, line_buffer_reset, row_length,
               shifting_filter, shifting_line, dense_valid, mac_enable, out_valid, out_last
    );
endinterface

// File: rtl/dense_seq_ctrl_load_cnt.sv
// dense_load_cnt: handshake-qualified tap counter, shared by the weight and feature load phases
module dense_load_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear_i,
    input  logic       en_i,
    input  logic [7:0] k_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       shift_o,
    output logic       last_o
);
    logic [7:0] cnt_q;
    assign ready_o = en_i;
    assign shift_o = en_i & valid_i;
    assign last_o  = shift_o && (cnt_q + 8'd1 == k_i);
    // self-clears on the k-th accept so the next load phase starts from zero
    always_ff @(posedge clk) begin
        if (rst || clear_i || last_o) cnt_q <= '0;
        else if (shift_o)             cnt_q <= cnt_q + 8'd1;
    end
endmodule

// File: rtl/dense_seq_ctrl.sv
// dense_seq_ctrl: chunks an in_len feature vector into TAPS-wide MAC passes
// (clear line buffer, load weights, load features, fire MAC, emit result)
module dense_seq_ctrl import dense_seq_ctrl_pkg::*; #(
    parameter int TAPS     = TAPS_DEF,
    parameter int LEN_W    = 16,
    parameter int MAC_LAT  = MAC_LAT_DEF,
    parameter int ROWLEN_W = ROWLEN_W_DEF
) (
    input logic              clk,
    input logic              rst,
    dense_seq_ctrl_if.master bus
);
    state_e           state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [7:0]       k_q, k_d, k_new, wait_q, wait_d;
    logic             zdone_q, zdone_d;
    logic             ld_en, ld_valid, ld_ready, ld_shift, ld_last, last_chunk;

    assign k_new      = chunk_k(32'(rem_q), TAPS);
    assign last_chunk = rem_q == '0;
    assign ld_en      = (state_q == LOAD_W) || (state_q == LOAD_X);
    assign ld_valid   = (state_q == LOAD_W) ? bus.weight_valid : bus.feature_valid;

    dense_load_cnt u_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear_i (state_q == CLEAR),
        .en_i    (ld_en),
        .k_i     (k_q),
        .valid_i (ld_valid),
        .ready_o (ld_ready),
        .shift_o (ld_shift),
        .last_o  (ld_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            k_q     <= '0;
            wait_q  <= '0;
            zdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            k_q     <= k_d;
            wait_q  <= wait_d;
            zdone_q <= zdone_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        k_d     = k_q;
        wait_d  = wait_q;
        zdone_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start && bus.in_len == '0) zdone_d = 1'b1;
                else if (bus.start) begin
                    rem_d   = bus.in_len;
                    state_d = CLEAR;
                end
            end
            CLEAR:  begin
                k_d     = k_new;
                state_d = LOAD_W;
            end
            LOAD_W: state_d = ld_last ? LOAD_X : LOAD_W;
            LOAD_X: state_d = ld_last ? FIRE : LOAD_X;
            FIRE: begin
                rem_d   = rem_q - LEN_W'(k_q);
                wait_d  = '0;
                state_d = (MAC_LAT > 1) ? WAIT : EMIT;
            end
            WAIT: begin
                wait_d  = wait_q + 8'd1;
                state_d = (wait_q == 8'(MAC_LAT - 2)) ? EMIT : WAIT;
            end
            EMIT: begin
                k_d     = last_chunk ? 8'd0 : k_q;
                state_d = last_chunk ? IDLE : CLEAR;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy              = state_q != IDLE;
    assign bus.done              = zdone_q || (state_q == EMIT && last_chunk);
    assign bus.weight_ready      = ld_ready && state_q == LOAD_W;
    assign bus.feature_ready     = ld_ready && state_q == LOAD_X;
    assign bus.shifting_filter   = ld_shift && state_q == LOAD_W;
    assign bus.shifting_line     = ld_shift && state_q == LOAD_X;
    assign bus.line_buffer_reset = state_q == CLEAR;
    assign bus.row_length        = ROWLEN_W'(ROWLEN_DENSE);
    assign bus.dense_valid       = (state_q == CLEAR) ? k_new : k_q;
    assign bus.mac_enable        = state_q == FIRE;
    assign bus.out_valid         = state_q == EMIT;
    assign bus.out_last          = state_q == EMIT && last_chunk;
endmodule

// File: tb/tb_dense_seq_ctrl.sv
// tb_dense_seq_ctrl: scoreboard bench; the reference model expands in_len into expected chunk results
module tb_dense_seq_ctrl;
    typedef struct {int k; bit last;} exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dense_seq_ctrl_if #(.LEN_W(16), .ROWLEN_W(8)) bus();
    dense_seq_ctrl #(.TAPS(9), .LEN_W(16), .MAC_LAT(2), .ROWLEN_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   checks = 0, errors = 0, cyc = 0, start_cyc = 0;
    int   w_hs = 0, f_hs = 0, lbr = 0, lbr_total = 0, w_total = 0, f_total = 0;
    int   done_cnt = 0, busy_cnt = 0, inv_err = 0, mac_cyc = 0, ov_cyc = 0, done_cyc = 0;
    bit   rnd_mode = 1'b0;
    exp_t q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // upstream sources: always-valid or coin-flip valid every cycle
    initial begin
        bus.weight_valid  = 1'b0;
        bus.feature_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.weight_valid  = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.feature_valid = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // monitor: protocol invariants, handshake counting, scoreboard pop on out_valid
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                w_hs = 0;
                f_hs = 0;
                lbr  = 0;
            end else begin
                if (bus.shifting_filter !== (bus.weight_valid & bus.weight_ready) ||
                    bus.shifting_line !== (bus.feature_valid & bus.feature_ready) ||
                    (bus.weight_ready & bus.feature_ready) || bus.row_length !== 8'd1) inv_err++;
                w_hs    += int'(bus.weight_valid & bus.weight_ready);
                f_hs    += int'(bus.feature_valid & bus.feature_ready);
                w_total += int'(bus.weight_valid & bus.weight_ready);
                f_total += int'(bus.feature_valid & bus.feature_ready);
                lbr       += int'(bus.line_buffer_reset);
                lbr_total += int'(bus.line_buffer_reset);
                busy_cnt  += int'(bus.busy);
                if (bus.done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (bus.mac_enable) mac_cyc = cyc;
                if (bus.out_valid) begin
                    ov_cyc = cyc;
                    if (q.size() == 0) chk("unexpected out_valid", 1, 0);
                    else begin
                        e = q.pop_front();
                        chk("dense_valid", 32'(bus.dense_valid), e.k);
                        chk("out_last", 32'(bus.out_last), 32'(e.last));
                        chk("done with out_valid", 32'(bus.done), 32'(e.last));
                        chk("weight handshakes per chunk", w_hs, e.k);
                        chk("feature handshakes per chunk", f_hs, e.k);
                        chk("line_buffer_reset per chunk", lbr, 1);
                    end
                    w_hs = 0;
                    f_hs = 0;
                    lbr  = 0;
                end
            end
        end
    end

    // reference model: ceil(len/9) chunks, full 9-tap chunks except possibly the last
    task automatic push_vec(input int len);
        int rem = len;
        while (rem > 0) begin
            int k = (rem > 9) ? 9 : rem;
            rem -= k;
            q.push_back('{k, rem == 0});
        end
    endtask

    task automatic pulse_start(input int len);
        @(posedge clk);
        #1;
        bus.start  = 1'b1;
        bus.in_len = 16'(len);
        start_cyc  = cyc;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            seen = bus.done;
        end
        chk(name, 32'(seen), 1);
    endtask

    task automatic run(input int len, input string name);
        int d0 = done_cnt;
        push_vec(len);
        pulse_start(len);
        wait_done({name, " done seen"});
        repeat (3) @(negedge clk);
        chk({name, " scoreboard drained"}, q.size(), 0);
        chk({name, " single done"}, done_cnt - d0, 1);
    endtask

    initial begin
        int h0, b0, d0, l0;
        bit found;
        bus.start  = 1'b0;
        bus.in_len = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset busy", 32'(bus.busy), 0);
        chk("reset outputs", {bus.done, bus.weight_ready, bus.feature_ready, bus.line_buffer_reset,
            bus.shifting_filter, bus.shifting_line, bus.dense_valid, bus.mac_enable, bus.out_valid,
            bus.out_last}, 0);
        chk("reset row_length", 32'(bus.row_length), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        h0 = w_total;
        run(9, "len9");
        chk("len9 mac_enable cycle", mac_cyc - start_cyc, 20);
        chk("len9 out_valid after mac", ov_cyc - mac_cyc, 2);
        chk("len9 weight handshakes", w_total - h0, 9);

        h0 = w_total;
        l0 = lbr_total;
        run(20, "len20");
        chk("len20 weight handshakes", w_total - h0, 20);
        chk("len20 line_buffer_reset pulses", lbr_total - l0, 3);

        h0 = w_total + f_total;
        b0 = busy_cnt;
        run(0, "len0");
        chk("len0 done latency", done_cyc - start_cyc, 1);
        chk("len0 busy stays low", busy_cnt - b0, 0);
        chk("len0 no handshakes", w_total + f_total - h0, 0);

        rnd_mode = 1'b1;
        h0 = f_total;
        run(11, "rand len11");
        chk("rand len11 feature handshakes", f_total - h0, 11);
        run(20, "rand len20");
        rnd_mode = 1'b0;

        push_vec(20);
        l0 = lbr_total;
        pulse_start(20);
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge clk);
            found = (lbr_total - l0 == 2) && bus.feature_ready;
        end
        chk("reached chunk2 LOAD_X", 32'(found), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        @(negedge clk);
        chk("midrun rst busy", 32'(bus.busy), 0);
        chk("midrun rst outputs", {bus.done, bus.weight_ready, bus.feature_ready, bus.line_buffer_reset,
            bus.shifting_filter, bus.shifting_line, bus.dense_valid, bus.mac_enable, bus.out_valid,
            bus.out_last}, 0);
        d0 = done_cnt;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("midrun rst no done", done_cnt - d0, 0);
        run(5, "after rst len5");

        push_vec(9);
        d0 = done_cnt;
        pulse_start(9);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            found = bus.weight_ready;
        end
        chk("reached LOAD_W", 32'(found), 1);
        @(posedge clk);
        #1;
        bus.start  = 1'b1;
        bus.in_len = 16'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done("busy start done seen");
        repeat (40) @(negedge clk);
        chk("busy start ignored, drained", q.size(), 0);
        chk("busy start ignored, single done", done_cnt - d0, 1);

        chk("protocol invariants", inv_err, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
